ch_seq_ctrl: RTL and testbench

Segment sequencer for one playback channel. Holds a small table of {start address, stop address, repeat count} segments and drives the channel RAM controller's address/stop-address strobes, `playback_en` and `mode`, so a multi-segment pattern plays with no per-segment software intervention. Sits between the AXI/GPIO register block and the channel RAM controller, in the `s_axi_clk` domain.

---
 rtl/ch_seq_ctrl_pkg.sv | 29 ++
 rtl/ch_seg_table.sv | 46 ++++
 rtl/ch_seq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ch_seq_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch_seq_ctrl_pkg.sv
// Shared types and timing constants for the channel segment sequencer.
package ch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE_STOP,
    S_STROBE_ADDR,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [2:0] STROBE_HI  = 3'd2;
  localparam logic [2:0] STROBE_CYC = 3'd4;
  localparam logic [2:0] BLANK_CYC  = 3'd4;

  // Record fields are sized for the widest supported configuration;
  // narrower instances zero-extend into them.
  localparam int SEG_ADDR_MAX = 32;
  localparam int SEG_REP_MAX  = 16;

  typedef struct packed {
    logic [SEG_ADDR_MAX-1:0] start;
    logic [SEG_ADDR_MAX-1:0] stop;
    logic [SEG_REP_MAX-1:0]  reps;
  } seg_t;

endpackage

// File: rtl/ch_seg_table.sv
// Segment table: one synchronous write port, one combinational read port.
module ch_seg_table
  import ch_seq_pkg::*;
#(
  parameter int N_ADDR_BITS  = 20,
  parameter int N_SEG        = 8,
  parameter int SEG_IDX_BITS = 3,
  parameter int REP_BITS     = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [SEG_IDX_BITS-1:0] wr_idx_i,
  input  logic [N_ADDR_BITS-1:0]  wr_start_i,
  input  logic [N_ADDR_BITS-1:0]  wr_stop_i,
  input  logic [REP_BITS-1:0]     wr_reps_i,
  input  logic [SEG_IDX_BITS-1:0] rd_idx_i,
  output seg_t                    rd_seg_o
);

  logic [N_ADDR_BITS-1:0] start_q [N_SEG];
  logic [N_ADDR_BITS-1:0] stop_q  [N_SEG];
  logic [REP_BITS-1:0]    reps_q  [N_SEG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_SEG; i++) begin
        start_q[i] <= '0;
        stop_q[i]  <= '0;
        reps_q[i]  <= '0;
      end
    end else if (wr_en_i) begin
      start_q[wr_idx_i] <= wr_start_i;
      stop_q[wr_idx_i]  <= wr_stop_i;
      reps_q[wr_idx_i]  <= wr_reps_i;
    end
  end

  always_comb begin
    rd_seg_o = '0;
    rd_seg_o.start[N_ADDR_BITS-1:0] = start_q[rd_idx_i];
    rd_seg_o.stop[N_ADDR_BITS-1:0]  = stop_q[rd_idx_i];
    rd_seg_o.reps[REP_BITS-1:0]     = reps_q[rd_idx_i];
  end

endmodule

// File: rtl/ch_seq_ctrl.sv
// Segment sequencer: walks the segment table, strobes stop/start addresses
// into the channel RAM controller and advances on playback_done edges.
module ch_seq_ctrl
  import ch_seq_pkg::*;
#(
  parameter int N_ADDR_BITS  = 20,
  parameter int N_SEG        = 8,
  parameter int SEG_IDX_BITS = 3,
  parameter int REP_BITS     = 8
) (
  input  logic                    s_axi_clk,
  input  logic                    s_axi_reset,
  input  logic                    seg_wr_en,
  input  logic [SEG_IDX_BITS-1:0] seg_wr_idx,
  input  logic [N_ADDR_BITS-1:0]  seg_wr_start,
  input  logic [N_ADDR_BITS-1:0]  seg_wr_stop,
  input  logic [REP_BITS-1:0]     seg_wr_reps,
  input  logic [SEG_IDX_BITS-1:0] last_seg,
  input  logic                    loop_sequence,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    playback_done,
  output logic                    write_addr,
  output logic                    write_stop_addr,
  output logic [N_ADDR_BITS-1:0]  set_ram_addr,
  output logic [N_ADDR_BITS-1:0]  stop_addr,
  output logic                    playback_en,
  output logic                    loop_playback,
  output logic                    mode,
  output logic                    busy,
  output logic                    seq_done,
  output logic                    aborted,
  output logic                    seg_err,
  output logic [SEG_IDX_BITS-1:0] cur_seg,
  output logic [REP_BITS-1:0]     rep_left
);

  state_t                  state_q;
  logic [2:0]              cnt_q;
  logic                    write_addr_q, write_stop_addr_q, playback_en_q;
  logic                    busy_q, seq_done_q, aborted_q, seg_err_q;
  logic [N_ADDR_BITS-1:0]  set_ram_addr_q, stop_addr_q;
  logic [SEG_IDX_BITS-1:0] cur_seg_q;
  logic [REP_BITS-1:0]     rep_left_q;
  logic                    pd_s1_q, pd_s2_q, pd_s3_q, pd_edge_q;

  seg_t                    rd_seg;
  logic [REP_BITS-1:0]     reps_eff;

  ch_seg_table #(
    .N_ADDR_BITS (N_ADDR_BITS),
    .N_SEG       (N_SEG),
    .SEG_IDX_BITS(SEG_IDX_BITS),
    .REP_BITS    (REP_BITS)
  ) u_table (
    .clk_i     (s_axi_clk),
    .rst_i     (s_axi_reset),
    .wr_en_i   (seg_wr_en),
    .wr_idx_i  (seg_wr_idx),
    .wr_start_i(seg_wr_start),
    .wr_stop_i (seg_wr_stop),
    .wr_reps_i (seg_wr_reps),
    .rd_idx_i  (cur_seg_q),
    .rd_seg_o  (rd_seg)
  );

  // A programmed play count of zero means "play once".
  assign reps_eff = (rd_seg.reps == '0) ? REP_BITS'(1) : rd_seg.reps[REP_BITS-1:0];

  // playback_done crosses from the playback clock: 2-flop sync, then edge.
  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      pd_s1_q   <= 1'b0;
      pd_s2_q   <= 1'b0;
      pd_s3_q   <= 1'b0;
      pd_edge_q <= 1'b0;
    end else begin
      pd_s1_q   <= playback_done;
      pd_s2_q   <= pd_s1_q;
      pd_s3_q   <= pd_s2_q;
      pd_edge_q <= pd_s2_q & ~pd_s3_q;
    end
  end

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      write_addr_q      <= 1'b0;
      write_stop_addr_q <= 1'b0;
      playback_en_q     <= 1'b0;
      busy_q            <= 1'b0;
      seq_done_q        <= 1'b0;
      aborted_q         <= 1'b0;
      seg_err_q         <= 1'b0;
      set_ram_addr_q    <= '0;
      stop_addr_q       <= '0;
      cur_seg_q         <= '0;
      rep_left_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            seq_done_q <= 1'b0;
            aborted_q  <= 1'b0;
            seg_err_q  <= 1'b0;
            cur_seg_q  <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (rd_seg.stop < rd_seg.start) begin
            seg_err_q  <= 1'b1;
            seq_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            rep_left_q        <= reps_eff;
            set_ram_addr_q    <= rd_seg.start[N_ADDR_BITS-1:0];
            stop_addr_q       <= rd_seg.stop[N_ADDR_BITS-1:0];
            write_stop_addr_q <= 1'b1;
            cnt_q             <= '0;
            state_q           <= S_STROBE_STOP;
          end
        end
        S_STROBE_STOP: begin
          if (cnt_q == STROBE_CYC - 3'd1) begin
            cnt_q        <= '0;
            write_addr_q <= 1'b1;
            state_q      <= S_STROBE_ADDR;
          end else begin
            cnt_q             <= cnt_q + 3'd1;
            write_stop_addr_q <= (cnt_q + 3'd1) < STROBE_HI;
          end
        end
        S_STROBE_ADDR: begin
          if (cnt_q == STROBE_CYC - 3'd1) begin
            cnt_q         <= '0;
            playback_en_q <= 1'b1;
            state_q       <= S_RUN;
          end else begin
            cnt_q        <= cnt_q + 3'd1;
            write_addr_q <= (cnt_q + 3'd1) < STROBE_HI;
          end
        end
        S_RUN: begin
          // cnt_q saturates at BLANK_CYC; edges before that are stale dones.
          if (pd_edge_q && cnt_q == BLANK_CYC) begin
            playback_en_q <= 1'b0;
            state_q       <= S_NEXT;
          end else if (cnt_q != BLANK_CYC) begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_NEXT: begin
          rep_left_q <= rep_left_q - REP_BITS'(1);
          if (rep_left_q != REP_BITS'(1)) begin
            write_addr_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= S_STROBE_ADDR;
          end else if (cur_seg_q != last_seg) begin
            cur_seg_q <= cur_seg_q + SEG_IDX_BITS'(1);
            state_q   <= S_LOAD;
          end else if (loop_sequence) begin
            cur_seg_q <= '0;
            state_q   <= S_LOAD;
          end else begin
            seq_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (abort && busy_q) begin
        state_q           <= S_IDLE;
        playback_en_q     <= 1'b0;
        write_addr_q      <= 1'b0;
        write_stop_addr_q <= 1'b0;
        aborted_q         <= 1'b1;
        busy_q            <= 1'b0;
      end
    end
  end

  assign write_addr      = write_addr_q;
  assign write_stop_addr = write_stop_addr_q;
  assign set_ram_addr    = set_ram_addr_q;
  assign stop_addr       = stop_addr_q;
  assign playback_en     = playback_en_q;
  assign loop_playback   = 1'b0;
  assign mode            = 1'b0;
  assign busy            = busy_q;
  assign seq_done        = seq_done_q;
  assign aborted         = aborted_q;
  assign seg_err         = seg_err_q;
  assign cur_seg         = cur_seg_q;
  assign rep_left        = rep_left_q;

endmodule

// File: tb/tb_ch_seq_ctrl.sv
// Directed bench for ch_seq_ctrl: one task per scenario with inline checks.
module tb_ch_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seg_wr_en = 1'b0;
  logic [2:0]  seg_wr_idx = '0;
  logic [19:0] seg_wr_start = '0, seg_wr_stop = '0;
  logic [7:0]  seg_wr_reps = '0;
  logic [2:0]  last_seg = '0;
  logic        loop_sequence = 1'b0, start = 1'b0, abort = 1'b0, playback_done = 1'b0;
  logic        write_addr, write_stop_addr, playback_en, loop_playback, mode;
  logic        busy, seq_done, aborted, seg_err;
  logic [19:0] set_ram_addr, stop_addr;
  logic [2:0]  cur_seg;
  logic [7:0]  rep_left;
  logic [59:0] all_o;

  int checks = 0;
  int errors = 0;
  int wa_cnt = 0, ws_cnt = 0, pe_cnt = 0;
  logic wa_prev = 1'b0, ws_prev = 1'b0, pe_prev = 1'b0;

  ch_seq_ctrl dut (
    .s_axi_clk(clk), .s_axi_reset(rst),
    .seg_wr_en(seg_wr_en), .seg_wr_idx(seg_wr_idx),
    .seg_wr_start(seg_wr_start), .seg_wr_stop(seg_wr_stop), .seg_wr_reps(seg_wr_reps),
    .last_seg(last_seg), .loop_sequence(loop_sequence),
    .start(start), .abort(abort), .playback_done(playback_done),
    .write_addr(write_addr), .write_stop_addr(write_stop_addr),
    .set_ram_addr(set_ram_addr), .stop_addr(stop_addr),
    .playback_en(playback_en), .loop_playback(loop_playback), .mode(mode),
    .busy(busy), .seq_done(seq_done), .aborted(aborted), .seg_err(seg_err),
    .cur_seg(cur_seg), .rep_left(rep_left)
  );

  assign all_o = {write_addr, write_stop_addr, set_ram_addr, stop_addr, playback_en,
                  loop_playback, mode, busy, seq_done, aborted, seg_err, cur_seg, rep_left};

  always #5 clk = ~clk;

  // Rising-edge counters for the strobes and playback enable.
  always @(posedge clk) begin
    wa_prev <= write_addr;
    ws_prev <= write_stop_addr;
    pe_prev <= playback_en;
    if (write_addr && !wa_prev)      wa_cnt <= wa_cnt + 1;
    if (write_stop_addr && !ws_prev) ws_cnt <= ws_cnt + 1;
    if (playback_en && !pe_prev)     pe_cnt <= pe_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic prog_seg(input logic [2:0] idx, input logic [19:0] s, input logic [19:0] e,
                          input logic [7:0] r);
    seg_wr_en = 1'b1; seg_wr_idx = idx; seg_wr_start = s; seg_wr_stop = e; seg_wr_reps = r;
    step();
    seg_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_pe(output bit ok);
    int n = 0;
    while (!playback_en && n < 40) begin step(); n++; end
    ok = playback_en;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!seq_done && n < 40) begin step(); n++; end
    ok = seq_done;
  endtask

  // Raise playback_done past the blanking window, wait for playback_en to drop.
  task automatic pulse_done(output bit ok);
    int n = 0;
    repeat (2) step();
    playback_done = 1'b1;
    while (playback_en && n < 10) begin step(); n++; end
    ok = !playback_en;
    repeat (2) step();
    playback_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (all_o !== 60'd0) begin errors++; $display("FAIL reset_in got %h exp 0", all_o); end
    rst = 1'b0;
    step();
    checks++;
    if (all_o !== 60'd0) begin errors++; $display("FAIL reset_after got %h exp 0", all_o); end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    prog_seg(3'd0, 20'h010, 20'h01F, 8'd1);
    last_seg = 3'd0; loop_sequence = 1'b0;
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (write_stop_addr !== (c == 2 || c == 3)) begin
        errors++; $display("FAIL single_wsa c=%0d got %b", c, write_stop_addr);
      end
      checks++;
      if (write_addr !== (c == 6 || c == 7)) begin
        errors++; $display("FAIL single_wa c=%0d got %b", c, write_addr);
      end
      checks++;
      if (playback_en !== (c >= 10)) begin
        errors++; $display("FAIL single_pe c=%0d got %b", c, playback_en);
      end
      if (c == 2) begin
        checks++;
        if ({set_ram_addr, stop_addr, rep_left, busy} !== {20'h010, 20'h01F, 8'd1, 1'b1}) begin
          errors++; $display("FAIL single_load got %h %h %h %b exp 010 01f 01 1",
                             set_ram_addr, stop_addr, rep_left, busy);
        end
      end
      step();
    end
    step();
    playback_done = 1'b1;
    n = 0;
    while (playback_en && n < 10) begin step(); n++; end
    checks++;
    if (n < 3 || n > 4) begin errors++; $display("FAIL single_lat got %0d exp 3..4", n); end
    wait_done(ok);
    playback_done = 1'b0;
    checks++;
    if (!ok || busy !== 1'b0 || rep_left !== 8'd0) begin
      errors++; $display("FAIL single_done got done=%b busy=%b rep=%0d", seq_done, busy, rep_left);
    end
    step();
  endtask

  task automatic test_repeat();
    bit ok;
    int wa0, ws0;
    prog_seg(3'd0, 20'h020, 20'h02F, 8'd3);
    wa0 = wa_cnt; ws0 = ws_cnt;
    pulse_start();
    for (int r = 3; r >= 1; r--) begin
      wait_pe(ok);
      checks++;
      if (!ok || rep_left !== 8'(r)) begin
        errors++; $display("FAIL rep_left got %0d exp %0d pe=%b", rep_left, r, playback_en);
      end
      pulse_done(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rep_adv r=%0d got pe=1 exp 0", r); end
    end
    wait_done(ok);
    step();
    checks++;
    if (!ok || rep_left !== 8'd0) begin
      errors++; $display("FAIL rep_done got done=%b rep=%0d exp 1 0", seq_done, rep_left);
    end
    checks++;
    if (wa_cnt - wa0 != 3 || ws_cnt - ws0 != 1) begin
      errors++; $display("FAIL rep_strobes got wa=%0d ws=%0d exp 3 1", wa_cnt - wa0, ws_cnt - ws0);
    end
  endtask

  task automatic test_loop();
    bit ok;
    prog_seg(3'd0, 20'h000, 20'h0FF, 8'd1);
    prog_seg(3'd1, 20'h100, 20'h1FF, 8'd1);
    last_seg = 3'd1; loop_sequence = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      wait_pe(ok);
      checks++;
      if (!ok || cur_seg !== 3'(i % 2) || set_ram_addr !== ((i % 2 == 1) ? 20'h100 : 20'h000)
          || seq_done !== 1'b0) begin
        errors++; $display("FAIL loop i=%0d got seg=%0d addr=%h done=%b", i, cur_seg,
                           set_ram_addr, seq_done);
      end
      if (i == 1) begin
        pulse_start();
        checks++;
        if (cur_seg !== 3'd1 || busy !== 1'b1 || playback_en !== 1'b1) begin
          errors++; $display("FAIL start_busy got seg=%0d busy=%b pe=%b", cur_seg, busy, playback_en);
        end
      end
      pulse_done(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL loop_adv i=%0d got pe=1 exp 0", i); end
    end
    wait_pe(ok);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (playback_en !== 1'b0 || aborted !== 1'b1 || busy !== 1'b0 || seq_done !== 1'b0) begin
      errors++; $display("FAIL loop_abort got pe=%b ab=%b busy=%b done=%b", playback_en, aborted,
                         busy, seq_done);
    end
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || write_stop_addr !== 1'b0) begin
      errors++; $display("FAIL start_abort_idle got busy=%b wsa=%b exp 0 0", busy, write_stop_addr);
    end
    last_seg = 3'd0; loop_sequence = 1'b0;
  endtask

  task automatic test_abort_run();
    bit ok;
    prog_seg(3'd0, 20'h040, 20'h07F, 8'd1);
    pulse_start();
    wait_pe(ok);
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (!ok || playback_en !== 1'b0 || aborted !== 1'b1 || write_addr !== 1'b0) begin
      errors++; $display("FAIL abort_run got pe=%b ab=%b wa=%b exp 0 1 0", playback_en, aborted,
                         write_addr);
    end
    pulse_start();
    checks++;
    if (aborted !== 1'b0 || cur_seg !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart got ab=%b seg=%0d busy=%b exp 0 0 1", aborted, cur_seg, busy);
    end
    repeat (8) step();
    checks++;
    if (playback_en !== 1'b0) begin errors++; $display("FAIL restart_c9 got pe=%b exp 0", playback_en); end
    step();
    checks++;
    if (playback_en !== 1'b1 || set_ram_addr !== 20'h040) begin
      errors++; $display("FAIL restart_c10 got pe=%b addr=%h exp 1 040", playback_en, set_ram_addr);
    end
    pulse_done(ok);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_done got %b exp 1", seq_done); end
  endtask

  task automatic test_seg_err();
    int wa0, ws0, pe0;
    prog_seg(3'd0, 20'h080, 20'h040, 8'd1);
    wa0 = wa_cnt; ws0 = ws_cnt; pe0 = pe_cnt;
    pulse_start();
    step();
    checks++;
    if (seg_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL seg_err got err=%b busy=%b exp 1 0", seg_err, busy);
    end
    repeat (10) step();
    checks++;
    if (wa_cnt != wa0 || ws_cnt != ws0 || pe_cnt != pe0 || seg_err !== 1'b1) begin
      errors++; $display("FAIL seg_err_quiet got wa=%0d ws=%0d pe=%0d err=%b exp 0 0 0 1",
                         wa_cnt - wa0, ws_cnt - ws0, pe_cnt - pe0, seg_err);
    end
  endtask

  task automatic test_stale();
    bit ok;
    int n;
    prog_seg(3'd0, 20'h010, 20'h01F, 8'd1);
    pulse_start();
    repeat (7) step();
    playback_done = 1'b1;
    repeat (12) step();
    checks++;
    if (playback_en !== 1'b1 || busy !== 1'b1 || seg_err !== 1'b0) begin
      errors++; $display("FAIL stale got pe=%b busy=%b err=%b exp 1 1 0", playback_en, busy, seg_err);
    end
    playback_done = 1'b0;
    repeat (3) step();
    playback_done = 1'b1;
    n = 0;
    while (playback_en && n < 10) begin step(); n++; end
    checks++;
    if (n < 3 || n > 4) begin errors++; $display("FAIL fresh_lat got %0d exp 3..4", n); end
    wait_done(ok);
    playback_done = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL fresh_done got %b exp 1", seq_done); end
    step();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    pulse_start();
    wait_pe(ok);
    repeat (2) step();
    rst = 1'b1;
    step();
    checks++;
    if (!ok || all_o !== 60'd0) begin
      errors++; $display("FAIL reset_run got %h exp 0 (pe_seen=%b)", all_o, ok);
    end
    rst = 1'b0;
    step();
    pulse_start();
    step();
    checks++;
    if (rep_left !== 8'd1 || stop_addr !== 20'h0 || set_ram_addr !== 20'h0) begin
      errors++; $display("FAIL cleared_table got rep=%0d stop=%h addr=%h exp 1 0 0", rep_left,
                         stop_addr, set_ram_addr);
    end
    wait_pe(ok);
    pulse_done(ok);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cleared_done got %b exp 1", seq_done); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    test_reset();
    test_single();
    test_repeat();
    test_loop();
    test_abort_run();
    test_seg_err();
    test_stale();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
